// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Next-PC source selects, sequencer states and instruction size.
package pc_seq_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_CALL,
        SEL_RET
    } next_sel_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack used by pc_sequencer.
// Push when full overwrites the oldest entry; count saturates.
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top_data,
    output logic            empty
);

    localparam int AW = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(RAS_DEPTH);

    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   ptr_inc;
    logic [AW:0]     count;

    assign ptr_inc  = ptr + PTR_ONE;
    assign top_data = mem[ptr];
    assign empty    = (count == '0);

    // Top pointer and occupancy; a pop on an empty stack is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr   <= ptr_inc;
            count <= (count == CNT_MAX) ? count : count + CNT_ONE;
        end else if (pop && !empty) begin
            ptr   <= ptr - PTR_ONE;
            count <= count - CNT_ONE;
        end
    end

    // Entry storage; the new entry lands one slot above the old top.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[ptr_inc] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC select, stall hold, flush flag.
// Return-address stack enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int OFS_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             BRANCH,
    input  logic             ZERO,
    input  logic             JUMP,
    input  logic             CALL,
    input  logic             RET,
    input  logic [OFS_W-1:0] OFFSET,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  PC_4,
    output logic             FLUSH,
    output logic             RAS_EMPTY,
    output logic             RAS_ERR
);

    if (PC_W < 8) begin : g_pcw_chk
        $error("pc_sequencer: PC_W must be at least 8");
    end

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0)
    begin : g_depth_chk
        $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
    end

    seq_state_t      state_q;
    seq_state_t      state_d;
    next_sel_t       sel;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_4;
    logic [PC_W-1:0] ofs_sx;
    logic [PC_W-1:0] byte_ofs;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] jmp_tgt;
    logic            flush_q;

    assign pc_4     = pc_q + PC_W'(INSTR_BYTES);
    assign ofs_sx   = PC_W'($signed(OFFSET));
    assign byte_ofs = ofs_sx << 2;
    assign br_tgt   = pc_4 + byte_ofs;
    assign jmp_tgt  = {pc_4[PC_W-1:PC_W-4], byte_ofs[PC_W-5:0]};

    assign PC    = pc_q;
    assign PC_4  = pc_4;
    assign FLUSH = flush_q;

`ifdef PC_SEQUENCER_RAS_EN
    logic            push;
    logic            pop;
    logic            err_d;
    logic            err_q;
    logic            ras_empty;
    logic [PC_W-1:0] ras_top;

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .reset     (RESET),
        .push      (push),
        .pop       (pop),
        .push_data (pc_4),
        .top_data  (ras_top),
        .empty     (ras_empty)
    );

    assign RAS_EMPTY = ras_empty;
    assign RAS_ERR   = err_q;

    // Underflow pulse; cleared while stalled.
    always_ff @(posedge CLK) begin
        if (RESET || STALL) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign RAS_EMPTY = 1'b1;
    assign RAS_ERR   = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next-PC source; BOOT and stall cycles never redirect.
    always_comb begin
        state_d = state_q;
        sel     = SEL_SEQ;
`ifdef PC_SEQUENCER_RAS_EN
        push    = 1'b0;
        pop     = 1'b0;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            BOOT:    if (!STALL) state_d = RUN;
            RUN:     if (STALL) state_d = HOLD;
            HOLD:    if (!STALL) state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (state_q != BOOT && !STALL) begin
            if (RET) begin
`ifdef PC_SEQUENCER_RAS_EN
                if (!ras_empty) begin
                    sel = SEL_RET;
                    pop = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
`endif
            end else if (JUMP || CALL) begin
`ifdef PC_SEQUENCER_RAS_EN
                sel  = CALL ? SEL_CALL : SEL_JUMP;
                push = CALL;
`else
                sel = SEL_JUMP;
`endif
            end else if (BRANCH && ZERO) begin
                sel = SEL_BRANCH;
            end
        end
    end

    // Next-PC mux.
    always_comb begin
        pc_d = pc_4;
        unique case (sel)
            SEL_BRANCH: pc_d = br_tgt;
            SEL_JUMP:   pc_d = jmp_tgt;
            SEL_CALL:   pc_d = jmp_tgt;
`ifdef PC_SEQUENCER_RAS_EN
            SEL_RET:    pc_d = ras_top;
`endif
            default:    pc_d = pc_4;
        endcase
    end

    // PC and flush registers; a stall freezes PC and clears flush.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q    <= '0;
            flush_q <= 1'b0;
        end else if (STALL) begin
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= (sel != SEL_SEQ);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Expectations adapt to whether PC_SEQUENCER_RAS_EN is defined.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        BRANCH;
    logic        ZERO;
    logic        JUMP;
    logic        CALL;
    logic        RET;
    logic [7:0]  OFFSET;
    logic [31:0] PC;
    logic [31:0] PC_4;
    logic        FLUSH;
    logic        RAS_EMPTY;
    logic        RAS_ERR;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(
        .PC_W      (32),
        .OFS_W     (8),
        .RAS_DEPTH (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .STALL     (STALL),
        .BRANCH    (BRANCH),
        .ZERO      (ZERO),
        .JUMP      (JUMP),
        .CALL      (CALL),
        .RET       (RET),
        .OFFSET    (OFFSET),
        .PC        (PC),
        .PC_4      (PC_4),
        .FLUSH     (FLUSH),
        .RAS_EMPTY (RAS_EMPTY),
        .RAS_ERR   (RAS_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic b, input logic z, input logic j,
                         input logic c, input logic r, input logic [7:0] o);
        BRANCH = b;
        ZERO   = z;
        JUMP   = j;
        CALL   = c;
        RET    = r;
        OFFSET = o;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] ret_ras [5] = '{32'h104, 32'hC4, 32'h84, 32'h44, 32'h48};
    logic [31:0] ret_seq [5] = '{32'h144, 32'h148, 32'h14C, 32'h150,
                                 32'h154};

    initial begin
        RESET = 1'b1;
        STALL = 1'b0;
        drive(0, 0, 0, 0, 0, 8'h00);
        tick();
        tick();
        check("rst_pc", PC, 32'h0);
        check("rst_pc4", PC_4, 32'h4);
        check("rst_flush", FLUSH, 0);
        check("rst_err", RAS_ERR, 0);
        check("rst_empty", RAS_EMPTY, 1);

        RESET = 1'b0;
        drive(0, 0, 1, 0, 0, 8'h40);
        tick();
        check("boot_pc", PC, 32'h4);
        check("boot_flush", FLUSH, 0);
        drive(0, 0, 0, 0, 0, 8'h00);
        tick();
        check("run_pc8", PC, 32'h8);
        tick();
        check("run_pc12", PC, 32'hC);
        check("run_flush", FLUSH, 0);

        drive(0, 0, 1, 0, 0, 8'h08);
        tick();
        check("jmp20_pc", PC, 32'h20);
        check("jmp20_flush", FLUSH, 1);
        drive(1, 1, 0, 0, 0, 8'hFE);
        tick();
        check("br_tk_pc", PC, 32'h1C);
        check("br_tk_flush", FLUSH, 1);
        drive(0, 0, 0, 0, 0, 8'h00);
        tick();
        check("seq20_pc", PC, 32'h20);
        check("seq20_flush", FLUSH, 0);
        drive(1, 0, 0, 0, 0, 8'hFE);
        tick();
        check("br_nt_pc", PC, 32'h24);
        check("br_nt_flush", FLUSH, 0);
        drive(0, 1, 0, 0, 0, 8'hFE);
        tick();
        check("zero_only_pc", PC, 32'h28);

        drive(1, 1, 0, 0, 0, 8'hF2);
        tick();
        check("br_wrap_neg", PC, 32'hFFFF_FFF4);
        drive(0, 0, 1, 0, 0, 8'h04);
        tick();
        check("jmp_hi_pc", PC, 32'hF000_0010);
        drive(0, 0, 1, 0, 0, 8'h05);
        tick();
        check("jmp_05_pc", PC, 32'hF000_0014);
        drive(0, 0, 1, 0, 0, 8'h80);
        tick();
        check("jmp_neg_pc", PC, 32'hFFFF_FE00);
        drive(1, 1, 0, 0, 0, 8'h7F);
        tick();
        check("br_wrap_pos", PC, 32'h0);

        drive(0, 0, 1, 0, 0, 8'h10);
        tick();
        check("jmp40_pc", PC, 32'h40);
        drive(0, 0, 0, 1, 0, 8'h10);
        tick();
        check("call_pc", PC, 32'h40);
        check("call_flush", FLUSH, 1);
        check("call_empty", RAS_EMPTY, RAS ? 0 : 1);
        drive(0, 0, 0, 0, 1, 8'h00);
        tick();
        check("ret_pc", PC, 32'h44);
        check("ret_flush", FLUSH, RAS ? 1 : 0);
        check("ret_empty", RAS_EMPTY, 1);

        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 1, 0, 8'(k * 16));
            tick();
            check($sformatf("call%0d_pc", k), PC, 32'(k * 64));
            check($sformatf("call%0d_empty", k), RAS_EMPTY, RAS ? 0 : 1);
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 1, 8'h00);
            tick();
            check($sformatf("pop%0d_pc", k), PC,
                  RAS ? ret_ras[k] : ret_seq[k]);
            check($sformatf("pop%0d_flush", k), FLUSH,
                  (RAS && k < 4) ? 1 : 0);
            check($sformatf("pop%0d_err", k), RAS_ERR,
                  (RAS && k == 4) ? 1 : 0);
        end
        check("pop_end_empty", RAS_EMPTY, 1);
        drive(0, 0, 0, 0, 0, 8'h00);
        tick();
        check("err_clear", RAS_ERR, 0);
        check("idle_pc", PC, RAS ? 32'h4C : 32'h158);

        drive(0, 0, 0, 1, 0, 8'h30);
        tick();
        check("callc0_pc", PC, 32'hC0);
        drive(0, 0, 0, RAS, 1, 8'h10);
        tick();
        check("retcall_pc", PC, RAS ? 32'h50 : 32'hC4);
        check("retcall_flush", FLUSH, RAS ? 1 : 0);
        check("retcall_empty", RAS_EMPTY, 1);

        drive(0, 0, 0, 1, 0, 8'h20);
        tick();
        check("call80_pc", PC, 32'h80);
        STALL = 1'b1;
        drive(0, 0, 1, 0, 0, 8'h07);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall%0d_pc", k), PC, 32'h80);
            check($sformatf("stall%0d_flush", k), FLUSH, 0);
            check($sformatf("stall%0d_empty", k), RAS_EMPTY, RAS ? 0 : 1);
        end
        STALL = 1'b0;
        drive(0, 0, 0, 0, 1, 8'h00);
        tick();
        check("unstall_ret_pc", PC, RAS ? 32'h54 : 32'h84);
        check("unstall_ret_flush", FLUSH, RAS ? 1 : 0);

        drive(0, 0, 0, 1, 0, 8'h20);
        tick();
        check("call80b_pc", PC, 32'h80);
        STALL = 1'b1;
        drive(0, 0, 1, 0, 0, 8'h07);
        tick();
        check("stall_b_pc", PC, 32'h80);
        RESET = 1'b1;
        tick();
        check("stall_rst_pc", PC, 32'h0);
        check("stall_rst_empty", RAS_EMPTY, 1);
        check("stall_rst_flush", FLUSH, 0);

        RESET = 1'b0;
        STALL = 1'b0;
        drive(0, 0, 1, 0, 0, 8'h10);
        tick();
        check("reboot_pc", PC, 32'h4);
        check("reboot_flush", FLUSH, 0);
        tick();
        check("rerun_pc", PC, 32'h40);
        check("rerun_flush", FLUSH, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
